csa_resolve_seq: RTL and testbench

- Converts a carry-save pair from the compressor tree back into a single binary word: out_res = in_sum + (in_carry << 1).
- in_carry carries weight +1, as emitted by the 4-to-2 compressors.
- Multi-cycle carry-propagate adder: CHUNK bits per cycle, ripple carry held in a register between steps.
- Sits at the tail of multiplier and multi-operand-adder datapaths, with valid/ready on both sides.

---
 rtl/csa_resolve_seq.sv | 191 +++++++++++++++++++
 tb/tb_csa_resolve_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_seq.sv
`default_nettype none
// ============================================================================
//  Module   : csa_resolve_seq
//  Purpose  : Multi-cycle carry-propagate adder that collapses a carry-save
//             pair into one exact binary word:
//                 out_res = in_sum + (in_carry << 1)
//             CHUNK result bits are resolved per clock.  The ripple carry
//             between chunks is held in a register.
//  Ports    : clk, rst            - clock (rising edge), synchronous active-high reset
//             in_valid/in_ready   - operand handshake (in_ready = IDLE)
//             in_sum, in_carry    - carry-save vectors, weights 0 and +1
//             out_valid/out_ready - result handshake (out_valid = DONE)
//             out_res             - WIDTH+2 bit exact result
//             out_busy            - high while resolving (BUSY)
//  Options  : CSA_RESOLVE_EARLY_EN - when defined, the block finishes as soon
//             as no carry is pending and all higher operand bits are zero.
//  Revision : 1.0 - initial release
// ============================================================================
module csa_resolve_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_sum,
    input  logic [WIDTH-1:0]   in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   out_res,
    output logic               out_busy
);

    localparam int c_EW    = WIDTH + 2;
    localparam int c_NSTEP = (c_EW + CHUNK - 1) / CHUNK;
    localparam int c_SW    = (c_NSTEP > 1) ? $clog2(c_NSTEP) : 1;
    localparam logic [c_SW-1:0] c_LAST = c_SW'(c_NSTEP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [c_EW-1:0]    r_a;
    logic [c_EW-1:0]    r_b;
    logic [c_EW-1:0]    r_res;
    logic [c_SW-1:0]    r_step;
    logic               r_carry;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK:0]     w_sum;
    logic               w_cout;
    logic [c_EW-1:0]    w_res_next;
    logic               w_last;

    // Gather the operand bits of the current chunk.  Positions past the top
    // of the extended word stay zero, which handles a partial final chunk.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < c_EW; i++) begin
            if ((i / CHUNK) == int'(r_step)) begin
                w_a_chunk[i % CHUNK] = r_a[i];
                w_b_chunk[i % CHUNK] = r_b[i];
            end
        end
    end

    assign w_sum  = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_cout = w_sum[CHUNK];
    assign w_last = (r_step == c_LAST);

    // Merge the freshly computed chunk into the result word.
    always_comb begin
        w_res_next = r_res;
        for (int i = 0; i < c_EW; i++) begin
            if ((i / CHUNK) == int'(r_step)) begin
                w_res_next[i] = w_sum[i % CHUNK];
            end
        end
    end

`ifdef CSA_RESOLVE_EARLY_EN
    // True when no operand bit above the current chunk is set.  Combined with
    // a zero carry-out, every remaining result bit is known to be zero and
    // already holds that value from the clear at capture.
    logic w_hi_zero;

    always_comb begin
        w_hi_zero = 1'b1;
        for (int i = 0; i < c_EW; i++) begin
            if ((i / CHUNK) > int'(r_step)) begin
                if (r_a[i] || r_b[i]) begin
                    w_hi_zero = 1'b0;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_busy     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                out_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
`ifdef CSA_RESOLVE_EARLY_EN
                else if (!w_cout && w_hi_zero) begin
                    w_state_next = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_step  <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= {2'b00, in_sum};
                        r_b     <= {1'b0, in_carry, 1'b0};
                        r_res   <= '0;
                        r_step  <= '0;
                        r_carry <= 1'b0;
                    end
                end
                BUSY: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_step  <= r_step + c_SW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign out_res = r_res;

endmodule
`default_nettype wire

// File: tb/tb_csa_resolve_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_resolve_seq
//  Purpose  : Self-checking bench for csa_resolve_seq (default parameters).
//             Expected results come from plain wide arithmetic; expected
//             latency comes from the chunk-count rule evaluated on the
//             operand values.  Honours CSA_RESOLVE_EARLY_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa_resolve_seq;

    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int c_EW    = WIDTH + 2;
    localparam int c_NSTEP = (c_EW + CHUNK - 1) / CHUNK;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_sum;
    logic [WIDTH-1:0]   in_carry;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH+1:0]   out_res;
    logic               out_busy;

    int n_vec = 0;
    int n_err = 0;

    csa_resolve_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_busy  (out_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] ref_sum(input logic [63:0] s, input logic [63:0] c);
        return 128'(s) + (128'(c) * 2);
    endfunction

    // Cycles from the accepting cycle T to the first cycle with out_valid.
    function automatic int ref_lat(input logic [63:0] s, input logic [63:0] c);
`ifdef CSA_RESOLVE_EARLY_EN
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] lim;
        a = 128'(s);
        b = 128'(c) * 2;
        for (int k = 0; k < c_NSTEP; k++) begin
            lim = 128'd1 << ((k + 1) * CHUNK);
            if (k == c_NSTEP - 1) return k + 2;
            if (((a % lim) + (b % lim)) < lim && (a / lim) == 0 && (b / lim) == 0)
                return k + 2;
        end
        return c_NSTEP + 1;
`else
        if (s == c) return c_NSTEP + 1;  // value-independent fixed latency
        return c_NSTEP + 1;
`endif
    endfunction

    // Wait (bounded) for out_valid; called at posedge+1.  Returns latency.
    task automatic wait_result(output int lat);
        int cnt;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        lat = cnt + 1;
    endtask

    // Full transaction; entered and left at posedge+1 with the DUT idle.
    task automatic run_op(input logic [63:0] s, input logic [63:0] c,
                          input int hold, input string tag);
        int lat;
        logic [127:0] held;
        in_sum   = s;
        in_carry = c;
        in_valid = 1'b1;
        chk({tag, " in_ready idle"}, 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sum   = {$urandom(), $urandom()};
        in_carry = {$urandom(), $urandom()};
        chk({tag, " busy"}, 128'(out_busy), 128'd1);
        wait_result(lat);
        chk({tag, " latency"}, 128'(lat), 128'(ref_lat(s, c)));
        chk({tag, " res"}, 128'(out_res), ref_sum(s, c));
        chk({tag, " in_ready done"}, 128'(in_ready), 128'd0);
        held = 128'(out_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold valid"}, 128'(out_valid), 128'd1);
            chk({tag, " hold res"}, 128'(out_res), held);
            chk({tag, " hold in_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " consumed valid"}, 128'(out_valid), 128'd0);
        chk({tag, " consumed in_ready"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        int lat;
        logic [63:0] s;
        logic [63:0] c;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sum = '0; in_carry = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset in_ready", 128'(in_ready), 128'd1);
        chk("reset out_busy", 128'(out_busy), 128'd0);
        chk("reset out_res", 128'(out_res), 128'd0);
        rst = 1'b0;

        // Directed cases
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, "max");
        run_op(64'd5, 64'd3, 0, "small");
        run_op(64'hFFFF, 64'd1, 0, "xchunk");
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 10, "backpressure");

        // Reset while step 2 is being computed
        in_sum = 64'hDEAD_BEEF_0123_4567; in_carry = 64'h7654_3210_FEDC_BA98;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("midrst out_valid", 128'(out_valid), 128'd0);
        chk("midrst out_busy", 128'(out_busy), 128'd0);
        chk("midrst in_ready", 128'(in_ready), 128'd1);
        chk("midrst out_res", 128'(out_res), 128'd0);
        run_op(64'h10, 64'h8, 0, "after_rst");

        // Back-to-back with in_valid held and out_ready tied high
        out_ready = 1'b1;
        in_sum = 64'd1; in_carry = 64'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_sum = 64'h100; in_carry = 64'h80;
        wait_result(lat);
        chk("b2b first latency", 128'(lat), 128'(ref_lat(64'd1, 64'd1)));
        chk("b2b first res", 128'(out_res), 128'h3);
        chk("b2b no early accept", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        chk("b2b idle in_ready", 128'(in_ready), 128'd1);
        chk("b2b idle busy", 128'(out_busy), 128'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b second accepted", 128'(out_busy), 128'd1);
        wait_result(lat);
        chk("b2b second latency", 128'(lat), 128'(ref_lat(64'h100, 64'h80)));
        chk("b2b second res", 128'(out_res), 128'h200);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b end in_ready", 128'(in_ready), 128'd1);

        // Randomized operands of mixed magnitude
        for (int n = 0; n < 24; n++) begin
            s = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            c = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            run_op(s, c, int'($urandom_range(0, 3)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
